// File: rtl/output_holder.sv
// output_holder: small byte FIFO that holds ciphertext until the chip user acknowledges each byte.
// Define OUTPUT_HOLDER_ACK_SYNC_EN to pass output_ack through a 2-flop synchroniser before edge detect.
module output_holder #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   input  logic                     output_ack,
   output logic [WIDTH-1:0]         data_out,
   output logic                     byte_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] ZERO_COUNT = {CW{1'b0}};
   localparam logic [AW-1:0] ZERO_PTR   = {AW{1'b0}};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             ack_q_r;

   logic             ack_s;
   logic             ack_rise_s;
   logic             in_ready_s;
   logic             push_s;
   logic             pop_s;
   logic [AW-1:0]    wr_ptr_next_s;
   logic [AW-1:0]    rd_ptr_next_s;
   logic [CW-1:0]    count_next_s;

`ifdef OUTPUT_HOLDER_ACK_SYNC_EN
   logic sync1_r;
   logic sync2_r;

   // Synchroniser resets high so a pin already high at reset release is not seen as an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= output_ack;
         sync2_r <= sync1_r;
      end
   end

   assign ack_s = sync2_r;
`else
   assign ack_s = output_ack;
`endif

   // Ack history for rising-edge detection; flush leaves it alone
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q_r <= 1'b1;
      end else begin
         ack_q_r <= ack_s;
      end
   end

   assign ack_rise_s = ack_s & ~ack_q_r;
   // Ready comes from the registered count only, so a full holder refuses even during a pop
   assign in_ready_s = (count_r != FULL_COUNT);
   assign push_s     = in_valid & in_ready_s;
   assign pop_s      = ack_rise_s & (count_r != ZERO_COUNT);

   // Next pointer and occupancy; flush wins over any concurrent push or pop
   always_comb begin
      wr_ptr_next_s = wr_ptr_r;
      rd_ptr_next_s = rd_ptr_r;
      count_next_s  = count_r;
      if (flush) begin
         wr_ptr_next_s = ZERO_PTR;
         rd_ptr_next_s = ZERO_PTR;
         count_next_s  = ZERO_COUNT;
      end else begin
         if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_next_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_next_s = rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= ZERO_PTR;
         rd_ptr_r <= ZERO_PTR;
         count_r  <= ZERO_COUNT;
      end else begin
         wr_ptr_r <= wr_ptr_next_s;
         rd_ptr_r <= rd_ptr_next_s;
         count_r  <= count_next_s;
      end
   end

   // Byte storage is deliberately not reset; a dropped flush-cycle byte is never written
   always_ff @(posedge clk) begin
      if (!rst && !flush && push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Outputs are decoded purely from registers
   always_comb begin
      in_ready   = in_ready_s;
      byte_ready = (count_r != ZERO_COUNT);
      count      = count_r;
      data_out   = {WIDTH{1'b0}};
      if (count_r != ZERO_COUNT) begin
         data_out = mem_r[rd_ptr_r];
      end else begin
         data_out = {WIDTH{1'b0}};
      end
   end

endmodule

// File: tb/tb_output_holder.sv
// Testbench for output_holder: directed steps plus random traffic, checked against a queue model.
module tb_output_holder;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;
`ifdef OUTPUT_HOLDER_ACK_SYNC_EN
   localparam int ACK_LAT = 3;
`else
   localparam int ACK_LAT = 1;
`endif

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [WIDTH-1:0]      in_data = 8'h00;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic                  flush = 1'b0;
   logic                  output_ack = 1'b0;
   logic [WIDTH-1:0]      data_out;
   logic                  byte_ready;
   logic [$clog2(DEPTH):0] count;

   int errors = 0;
   int checks = 0;

   // Reference model: the held bytes as a queue, plus the sampled ack history
   logic [WIDTH-1:0] q [$];
   bit m_ackq = 1'b1;
   bit m_s1   = 1'b1;
   bit m_s2   = 1'b1;

   output_holder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .output_ack(output_ack), .data_out(data_out),
      .byte_ready(byte_ready), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit ack_seen;
      bit rise;
      bit do_pop;
      bit do_push;
`ifdef OUTPUT_HOLDER_ACK_SYNC_EN
      ack_seen = m_s2;
`else
      ack_seen = output_ack;
`endif
      rise    = ack_seen && !m_ackq;
      do_pop  = rise && (q.size() != 0);
      do_push = in_valid && (q.size() != DEPTH);
      if (rst) begin
         q.delete();
         m_ackq = 1'b1;
         m_s1   = 1'b1;
         m_s2   = 1'b1;
      end else begin
         m_ackq = ack_seen;
         m_s2   = m_s1;
         m_s1   = output_ack;
         if (flush) begin
            q.delete();
         end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(in_data);
         end
      end
   endtask

   task automatic tick();
      logic [WIDTH-1:0] exp_data;
      model_edge();
      @(posedge clk);
      #1;
      exp_data = (q.size() != 0) ? q[0] : 8'h00;
      chk("model_count", 32'(count), 32'(q.size()));
      chk("model_byte_ready", 32'(byte_ready), 32'(q.size() != 0));
      chk("model_data_out", 32'(data_out), 32'(exp_data));
      chk("model_in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input logic [WIDTH-1:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic ack_pulse();
      output_ack = 1'b1;
      tick();
      output_ack = 1'b0;
      repeat (ACK_LAT) tick();
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'h00);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Single push is visible right after its edge
      push(8'hA5);
      chk("t1_byte_ready", 32'(byte_ready), 32'd1);
      chk("t1_data_out", 32'(data_out), 32'hA5);
      chk("t1_count", 32'(count), 32'd1);

      // Fill to full, then a refused fifth byte
      do_reset();
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      chk("t2_in_ready", 32'(in_ready), 32'd0);
      push(8'h55);
      chk("t2_count_full", 32'(count), 32'd4);
      chk("t2_data_out", 32'(data_out), 32'h11);

      // Drain by ack pulses, then one extra pulse while empty
      ack_pulse(); chk("t3_pop1", 32'(data_out), 32'h22);
      ack_pulse(); chk("t3_pop2", 32'(data_out), 32'h33);
      ack_pulse(); chk("t3_pop3", 32'(data_out), 32'h44);
      ack_pulse();
      chk("t3_empty_ready", 32'(byte_ready), 32'd0);
      chk("t3_empty_data", 32'(data_out), 32'h00);
      ack_pulse();
      chk("t3_extra_count", 32'(count), 32'd0);
      push(8'h66);
      chk("t3_no_pending_pop", 32'(count), 32'd1);

      // Held-high ack pops exactly once
      do_reset();
      push(8'h01); push(8'h02);
      output_ack = 1'b1;
      repeat (10) tick();
      chk("t4_count", 32'(count), 32'd1);
      chk("t4_data", 32'(data_out), 32'h02);
      output_ack = 1'b0;
      repeat (ACK_LAT + 1) tick();

      // Push and pop on the same edge
      output_ack = 1'b1;
      repeat (ACK_LAT - 1) tick();
      in_valid = 1'b1;
      in_data  = 8'h77;
      tick();
      in_valid = 1'b0;
      output_ack = 1'b0;
      chk("t5_count", 32'(count), 32'd1);
      chk("t5_data", 32'(data_out), 32'h77);
      repeat (ACK_LAT) tick();

      // Wrap the pointers with interleaved push/pop traffic
      for (int i = 0; i < 6; i++) begin
         push(8'(8'h80 + 8'(i)));
         ack_pulse();
      end
      chk("t5_wrap_count", 32'(count), 32'd1);
      chk("t5_wrap_data", 32'(data_out), 32'h85);

      // Flush with a concurrent byte drops everything
      do_reset();
      push(8'hC1); push(8'hC2); push(8'hC3);
      flush = 1'b1;
      in_valid = 1'b1;
      in_data = 8'hC4;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("t6_flush_count", 32'(count), 32'd0);
      chk("t6_flush_ready", 32'(byte_ready), 32'd0);
      chk("t6_flush_in_ready", 32'(in_ready), 32'd1);

      // Ack held high across reset release causes no pop
      output_ack = 1'b1;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      push(8'h99);
      repeat (6) tick();
      chk("t6_ack_through_rst", 32'(count), 32'd1);
      chk("t6_ack_through_rst_data", 32'(data_out), 32'h99);
      output_ack = 1'b0;
      repeat (ACK_LAT + 1) tick();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         in_valid   = 1'($urandom_range(0, 1));
         in_data    = 8'($urandom);
         output_ack = 1'($urandom_range(0, 1));
         flush      = ($urandom_range(0, 39) == 0);
         rst        = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
